// File: rtl/power_switch_sequencer.sv
// Power-switch sequencer for one switchable domain: orders switch, clock, reset
// and isolation on the way up and down, and traps pwr_good timeouts in FAULT.
module power_switch_sequencer #(
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned CLK_SETTLE = 4,
   parameter int unsigned RST_HOLD   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwr_req,
   input  logic pwr_good,
   input  logic fault_clr,
   output logic switch_en,
   output logic iso_en,
   output logic clk_en,
   output logic dom_rst_n,
   output logic pwr_on,
   output logic busy,
   output logic seq_done,
   output logic fault
);

   localparam int unsigned CNT_W = 8;

   // Counter values on the last cycle of each timed phase
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(CLK_SETTLE - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);

   typedef enum logic [3:0] {
      ST_OFF,
      ST_PWR_UP,
      ST_CLK_UP,
      ST_RST_REL,
      ST_ON,
      ST_ISO_SET,
      ST_RST_SET,
      ST_PWR_DN,
      ST_FAULT
   } state_t;

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;

   // Transition rules; a lost pwr_good while the domain is powered wins over progress
   function automatic state_t next_state(
      input state_t           cur,
      input logic [CNT_W-1:0] c,
      input logic             req,
      input logic             good,
      input logic             clr
   );
      next_state = cur;
      case (cur)
         ST_OFF: begin
            if (req) next_state = ST_PWR_UP;
         end
         ST_PWR_UP: begin
            if (good)                   next_state = ST_CLK_UP;
            else if (c == TIMEOUT_LAST) next_state = ST_FAULT;
         end
         ST_CLK_UP: begin
            if (!good)                  next_state = ST_FAULT;
            else if (c == SETTLE_LAST)  next_state = ST_RST_REL;
         end
         ST_RST_REL: begin
            if (!good)                  next_state = ST_FAULT;
            else if (c == HOLD_LAST)    next_state = ST_ON;
         end
         ST_ON: begin
            if (!good)                  next_state = ST_FAULT;
            else if (!req)              next_state = ST_ISO_SET;
         end
         ST_ISO_SET: begin
            next_state = ST_RST_SET;
         end
         ST_RST_SET: begin
            if (c == HOLD_LAST)         next_state = ST_PWR_DN;
         end
         ST_PWR_DN: begin
            if (!good)                  next_state = ST_OFF;
            else if (c == TIMEOUT_LAST) next_state = ST_FAULT;
         end
         ST_FAULT: begin
            if (clr)                    next_state = ST_OFF;
         end
         default: begin
            next_state = ST_OFF;
         end
      endcase
   endfunction

   assign nxt = next_state(state, cnt, pwr_req, pwr_good, fault_clr);

   // State, phase counter and all outputs update together from the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_OFF;
         cnt       <= '0;
         switch_en <= 1'b0;
         iso_en    <= 1'b1;
         clk_en    <= 1'b0;
         dom_rst_n <= 1'b0;
         pwr_on    <= 1'b0;
         busy      <= 1'b0;
         seq_done  <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state    <= nxt;
         cnt      <= (nxt == state) ? cnt + CNT_W'(1) : '0;
         pwr_on   <= (nxt == ST_ON);
         fault    <= (nxt == ST_FAULT);
         busy     <= (nxt != ST_OFF) && (nxt != ST_ON) && (nxt != ST_FAULT);
         seq_done <= ((state == ST_RST_REL) && (nxt == ST_ON)) ||
                     ((state == ST_PWR_DN)  && (nxt == ST_OFF));
         case (nxt)
            ST_PWR_UP: begin
               switch_en <= 1'b1; iso_en <= 1'b1; clk_en <= 1'b0; dom_rst_n <= 1'b0;
            end
            ST_CLK_UP, ST_RST_SET: begin
               switch_en <= 1'b1; iso_en <= 1'b1; clk_en <= 1'b1; dom_rst_n <= 1'b0;
            end
            ST_RST_REL, ST_ISO_SET: begin
               switch_en <= 1'b1; iso_en <= 1'b1; clk_en <= 1'b1; dom_rst_n <= 1'b1;
            end
            ST_ON: begin
               switch_en <= 1'b1; iso_en <= 1'b0; clk_en <= 1'b1; dom_rst_n <= 1'b1;
            end
            default: begin
               switch_en <= 1'b0; iso_en <= 1'b1; clk_en <= 1'b0; dom_rst_n <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Bench for power_switch_sequencer: directed sequences from the requirements,
// then randomized traffic checked cycle by cycle against a phase/age model.
module tb_power_switch_sequencer;

   localparam int TIMEOUT    = 64;
   localparam int CLK_SETTLE = 4;
   localparam int RST_HOLD   = 4;

   // Output vector order: switch_en iso_en clk_en dom_rst_n pwr_on busy seq_done fault
   localparam logic [7:0] O_OFF     = 8'b0100_0000;
   localparam logic [7:0] O_OFF_D   = 8'b0100_0010;
   localparam logic [7:0] O_PWR_UP  = 8'b1100_0100;
   localparam logic [7:0] O_CLK_UP  = 8'b1110_0100;
   localparam logic [7:0] O_RST_REL = 8'b1111_0100;
   localparam logic [7:0] O_ON      = 8'b1011_1000;
   localparam logic [7:0] O_ON_D    = 8'b1011_1010;
   localparam logic [7:0] O_ISO     = 8'b1111_0100;
   localparam logic [7:0] O_RST_SET = 8'b1110_0100;
   localparam logic [7:0] O_PWR_DN  = 8'b0100_0100;
   localparam logic [7:0] O_FAULT   = 8'b0100_0001;

   logic clk = 1'b0;
   logic rst_n, pwr_req, pwr_good, fault_clr;
   logic switch_en, iso_en, clk_en, dom_rst_n, pwr_on, busy, seq_done, fault;
   logic [7:0] outs;

   int checks = 0;
   int errors = 0;

   // Model: phase index 0..8 = OFF PWR_UP CLK_UP RST_REL ON ISO_SET RST_SET PWR_DN FAULT
   int   m_st   = 0;
   int   m_age  = 0;
   logic m_done = 1'b0;
   logic [3:0] lvl_tab [9] = '{4'b0100, 4'b1100, 4'b1110, 4'b1111, 4'b1011,
                               4'b1111, 4'b1110, 4'b0100, 4'b0100};

   always #5 clk = ~clk;

   assign outs = {switch_en, iso_en, clk_en, dom_rst_n, pwr_on, busy, seq_done, fault};

   power_switch_sequencer #(
      .TIMEOUT   (TIMEOUT),
      .CLK_SETTLE(CLK_SETTLE),
      .RST_HOLD  (RST_HOLD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwr_req  (pwr_req),
      .pwr_good (pwr_good),
      .fault_clr(fault_clr),
      .switch_en(switch_en),
      .iso_en   (iso_en),
      .clk_en   (clk_en),
      .dom_rst_n(dom_rst_n),
      .pwr_on   (pwr_on),
      .busy     (busy),
      .seq_done (seq_done),
      .fault    (fault)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_outs();
      logic b;
      b = (m_st >= 1 && m_st <= 3) || (m_st >= 5 && m_st <= 7);
      return {lvl_tab[m_st], m_st == 4, b, m_done, m_st == 8};
   endfunction

   // Advance the model by one edge; m_age = edges already spent in the phase
   task automatic model_edge();
      int nxt;
      if (!rst_n) begin
         m_st = 0; m_age = 0; m_done = 1'b0;
         return;
      end
      nxt = m_st;
      case (m_st)
         0: if (pwr_req) nxt = 1;
         1: if (pwr_good) nxt = 2; else if (m_age + 1 == TIMEOUT) nxt = 8;
         2: if (!pwr_good) nxt = 8; else if (m_age + 1 == CLK_SETTLE) nxt = 3;
         3: if (!pwr_good) nxt = 8; else if (m_age + 1 == RST_HOLD) nxt = 4;
         4: if (!pwr_good) nxt = 8; else if (!pwr_req) nxt = 5;
         5: nxt = 6;
         6: if (m_age + 1 == RST_HOLD) nxt = 7;
         7: if (!pwr_good) nxt = 0; else if (m_age + 1 == TIMEOUT) nxt = 8;
         8: if (fault_clr) nxt = 0;
         default: nxt = 0;
      endcase
      m_done = (m_st == 3 && nxt == 4) || (m_st == 7 && nxt == 0);
      m_age  = (nxt == m_st) ? m_age + 1 : 0;
      m_st   = nxt;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("model", outs, exp_outs());
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n = 1'b0; pwr_req = 1'b0; pwr_good = 1'b0; fault_clr = 1'b0;
      step();
      check("reset", outs, O_OFF);
      step();
      rst_n = 1'b1;
      step();
      check("off_idle", outs, O_OFF);

      // Power-up with pwr_good tied high
      pwr_good = 1'b1; pwr_req = 1'b1;
      step();  check("up_E", outs, O_PWR_UP);
      step();  check("up_E1", outs, O_CLK_UP);
      run(3);  step(); check("up_E5", outs, O_RST_REL);
      run(3);  check("up_E8", outs, O_RST_REL);
      step();  check("up_E9", outs, O_ON_D);
      step();  check("up_E10", outs, O_ON);

      // Power-down, pwr_good falling 3 cycles after switch_en
      pwr_req = 1'b0;
      step();  check("dn_E", outs, O_ISO);
      step();  check("dn_E1", outs, O_RST_SET);
      run(3);  check("dn_E4", outs, O_RST_SET);
      step();  check("dn_E5", outs, O_PWR_DN);
      run(3);  pwr_good = 1'b0;
      step();  check("dn_E9", outs, O_OFF_D);
      step();  check("dn_E10", outs, O_OFF);

      // pwr_good never arrives: 64 cycles in PWR_UP, then FAULT
      pwr_req = 1'b1;
      step();  check("to_E", outs, O_PWR_UP);
      run(62); step(); check("to_E63", outs, O_PWR_UP);
      step();  check("to_E64", outs, O_FAULT);
      run(5);  check("to_hold", outs, O_FAULT);
      fault_clr = 1'b1;
      step();  check("to_clr", outs, O_OFF);
      fault_clr = 1'b0; pwr_req = 1'b0;

      // Request withdrawn during CLK_UP: up sequence still completes
      pwr_good = 1'b1; pwr_req = 1'b1;
      step();  step(); check("tog_E1", outs, O_CLK_UP);
      pwr_req = 1'b0;
      run(7);  check("tog_E8", outs, O_RST_REL);
      step();  check("tog_E9", outs, O_ON_D);
      step();  check("tog_E10", outs, O_ISO);
      run(5);  check("tog_pdn", outs, O_PWR_DN);
      pwr_good = 1'b0;
      step();  check("tog_off", outs, O_OFF_D);

      // One-cycle pwr_good drop while ON
      pwr_req = 1'b1; pwr_good = 1'b1;
      run(11); check("gl_on", outs, O_ON);
      pwr_good = 1'b0;
      step();  check("gl_fault", outs, O_FAULT);
      pwr_good = 1'b1;
      run(2);  check("gl_hold", outs, O_FAULT);
      fault_clr = 1'b1; pwr_req = 1'b0;
      step();  check("gl_clr", outs, O_OFF);
      fault_clr = 1'b0;

      // Reset in RST_SET
      pwr_req = 1'b1;
      run(11); check("rs_on", outs, O_ON);
      pwr_req = 1'b0;
      step();  step(); step(); check("rs_rstset", outs, O_RST_SET);
      rst_n = 1'b0;
      step();  check("rs_mid", outs, O_OFF);
      rst_n = 1'b1;
      step();  check("rs_off", outs, O_OFF);
      pwr_req = 1'b1;
      step();  check("rs_restart", outs, O_PWR_UP);

      // Randomized traffic: pwr_good loosely follows switch_en with glitches
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 29) == 0) pwr_req = ~pwr_req;
         fault_clr = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0)
            pwr_good = ~pwr_good;
         else if (pwr_good != switch_en && $urandom_range(0, 2) == 0)
            pwr_good = switch_en;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
